mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 data multiplexer among four requesters.
- Registers the 2-bit select that steers the shared mux and presents the selected requester's data word on a single output.
- Enforces a bounded hold time so no requester can starve the others.
- Sits between four producer channels and one shared downstream consumer in the experiment datapath.

Parameters:
- W, 4: data width per requester channel.
- MAX_HOLD, 8: maximum consecutive grant cycles per ownership before pre-emption when others are waiting; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per channel; bit i = channel i wants the shared mux.
- din  input  4*W  channel data; channel i occupies bits [i*W+W-1 : i*W].
- grant  output  4  one-hot registered grant, or all-zero when idle.
- sel  output  2  registered mux select; equals the index of the granted channel.
- dout  output  W  din slice selected by sel; combinational from registered sel.
- dout_valid  output  1  high when a grant is held and that owner's req is high in the same cycle.

Behaviour:
- Reset (synchronous, active-high):
  - grant=0000, sel=00, dout_valid=0.
  - Round-robin pointer last=3, so channel 0 has first priority after reset.
  - Hold counter hold_cnt=0; state=IDLE.
  - Reset asserted mid-grant aborts the ownership at that edge; no carry-over of pointer or count.
- State machine, two states: IDLE and BUSY.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise pick the first requesting channel scanning last+1, last+2, ... modulo 4.
  - Register grant, sel and owner; set hold_cnt=1; go to BUSY.
  - Latency: req rising edge to grant = 1 clock.
- BUSY, evaluated every edge with owner = current sel:
  - (a) req[owner]=0 (release): last=owner. If any other req is set, grant the next one round-robin at the same edge with no idle bubble, hold_cnt=1. Otherwise grant=0 and go to IDLE.
  - (b) req[owner]=1, hold_cnt==MAX_HOLD, and some other req set (pre-emption): last=owner; grant the next requester round-robin; hold_cnt=1.
  - (c) req[owner]=1, hold_cnt==MAX_HOLD, and no other req: keep ownership; hold_cnt restarts at 1.
  - (d) otherwise keep ownership; hold_cnt saturating increment.
- Round-robin search always excludes the outgoing owner on release or pre-emption. It wraps 3 to 0.
- MAX_HOLD=1: the grant rotates every cycle among the active requesters.
- grant is always one-hot or zero; sel changes only at the same edges where grant changes.
- dout equals din[sel*W +: W] at all times, including while idle. Consumers qualify it with dout_valid.
- hold_cnt width is 8 bits; it never exceeds MAX_HOLD.
- Simultaneous release and new requests are resolved in a single edge per rule (a).

Decomposition:
- Shared include/package holds:
  - State encodings IDLE=1'b0, BUSY=1'b1.
  - Default constants for W and MAX_HOLD.
  - Channel count N_CH=4 and select width SEL_W=2.
- One natural sub-module: rr_pick4. It is purely combinational: given req[3:0], last[1:0] and an exclude enable, it returns found and idx[1:0].
- The data steering reuses the team's existing 2-to-1 mux cells, arranged as a two-level tree driven by sel.

Test Plan:
- Reset then req=0100 → one clock later grant=0100, sel=10, dout=din[11:8], dout_valid=1. With req held 20 cycles and others idle, grant stays 0100 throughout (rule c).
- Reset then req=1111 held, MAX_HOLD=8 → grant order 0001,0010,0100,1000,0001…. Each grant lasts exactly 8 cycles with no gap cycles.
- Owner 0 granted, req=0011 → at cycle 3 drop req[0] (req=0010). Next edge grant=0010, sel=01, hold_cnt=1, no IDLE cycle.
- req=1001 from reset → grant 0001 first. After channel 0 releases, grant 1000. After channel 3 releases with req[0] reasserted, grant 0001 (wrap 3→0). All-zero req → grant=0000, dout_valid=0 next edge.
- Mid-grant reset: owner 2, hold_cnt=5, reset pulsed one cycle with req=0110 held. During reset grant=0000; first post-reset grant=0010, because last=3 is reset and channel 1 wins over 2.
- MAX_HOLD=1, req=0101 held → grant alternates 0001,0100,0001… every cycle; sel alternates 00,10.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter_pkg
// Brief    : Shared constants for the round-robin 4-to-1 mux arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mux4_rr_arbiter_pkg;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    localparam int c_W_DEFAULT        = 4;
    localparam int c_MAX_HOLD_DEFAULT = 8;

    localparam int c_N_CH  = 4;
    localparam int c_SEL_W = 2;

endpackage : mux4_rr_arbiter_pkg
`default_nettype wire

// File: rtl/mux2_cell.sv
`default_nettype none
// ============================================================================
// Module   : mux2_cell
// Brief    : Generic W-bit 2-to-1 multiplexer cell.
// Revision : 1.0  initial release
// ============================================================================
module mux2_cell #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);

    assign y = s ? b : a;

endmodule : mux2_cell
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Brief    : Combinational round-robin picker over four requests.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [c_N_CH-1:0]  req,
    input  logic [c_SEL_W-1:0] last,
    input  logic               excl,
    output logic               found,
    output logic [c_SEL_W-1:0] idx
);

    logic [c_SEL_W-1:0] w_cand;

    // Scan last+1 .. last+4; the fourth candidate is 'last' itself and is
    // skipped when the outgoing owner must not win again.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = 1; k <= c_N_CH; k++) begin
            w_cand = last + c_SEL_W'(k);
            if (!found && req[w_cand] && !(excl && (k == c_N_CH))) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter with bounded hold steering a shared 4:1 mux.
// Revision : 1.0  initial release
// ============================================================================
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int W        = c_W_DEFAULT,
    parameter int MAX_HOLD = c_MAX_HOLD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [c_N_CH-1:0]    req,
    input  logic [c_N_CH*W-1:0]  din,
    output logic [c_N_CH-1:0]    grant,
    output logic [c_SEL_W-1:0]   sel,
    output logic [W-1:0]         dout,
    output logic                 dout_valid
);

    localparam logic [7:0] c_MAX_HOLD = 8'(MAX_HOLD);

    logic [0:0]          r_state;
    logic [c_N_CH-1:0]   r_grant;
    logic [c_SEL_W-1:0]  r_sel;
    logic [c_SEL_W-1:0]  r_last;
    logic [7:0]          r_hold;

    logic [0:0]          w_nxt_state;
    logic [c_N_CH-1:0]   w_nxt_grant;
    logic [c_SEL_W-1:0]  w_nxt_sel;
    logic [c_SEL_W-1:0]  w_nxt_last;
    logic [7:0]          w_nxt_hold;

    logic                w_busy;
    logic [c_SEL_W-1:0]  w_pick_last;
    logic                w_found;
    logic [c_SEL_W-1:0]  w_idx;
    logic                w_own_req;
    logic                w_expired;

    // While busy the search starts after the current owner and excludes it.
    assign w_busy      = (r_state == c_BUSY);
    assign w_pick_last = w_busy ? r_sel : r_last;
    assign w_own_req   = req[r_sel];
    assign w_expired   = (r_hold == c_MAX_HOLD);

    rr_pick4 u_pick (
        .req   (req),
        .last  (w_pick_last),
        .excl  (w_busy),
        .found (w_found),
        .idx   (w_idx)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_sel   = r_sel;
        w_nxt_last  = r_last;
        w_nxt_hold  = r_hold;
        if (!w_busy) begin
            if (w_found) begin
                w_nxt_state = c_BUSY;
                w_nxt_grant = c_N_CH'(1) << w_idx;
                w_nxt_sel   = w_idx;
                w_nxt_hold  = 8'd1;
            end
        end else if (!w_own_req || (w_expired && w_found)) begin
            w_nxt_last = r_sel;
            if (w_found) begin
                w_nxt_grant = c_N_CH'(1) << w_idx;
                w_nxt_sel   = w_idx;
                w_nxt_hold  = 8'd1;
            end else begin
                w_nxt_state = c_IDLE;
                w_nxt_grant = '0;
                w_nxt_hold  = 8'd0;
            end
        end else if (w_expired) begin
            w_nxt_hold = 8'd1;
        end else if (r_hold != 8'hFF) begin
            w_nxt_hold = r_hold + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_last  <= c_SEL_W'(c_N_CH - 1);
            r_hold  <= 8'd0;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_sel   <= w_nxt_sel;
            r_last  <= w_nxt_last;
            r_hold  <= w_nxt_hold;
        end
    end

    logic [W-1:0] w_lvl1 [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_leaf
            mux2_cell #(.W(W)) u_leaf (
                .a (din[(2*gi)*W   +: W]),
                .b (din[(2*gi+1)*W +: W]),
                .s (r_sel[0]),
                .y (w_lvl1[gi])
            );
        end
    endgenerate

    mux2_cell #(.W(W)) u_root (
        .a (w_lvl1[0]),
        .b (w_lvl1[1]),
        .s (r_sel[1]),
        .y (dout)
    );

    assign grant      = r_grant;
    assign sel        = r_sel;
    assign dout_valid = w_busy && w_own_req;

endmodule : mux4_rr_arbiter
`default_nettype wire
